// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU command path: sequencer states, command bytes
// and default datapath widths.
package alu_sys_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;
    localparam int unsigned ALU_FUN_WIDTH  = 4;

    // Command bytes, also decoded by the register-file command decoder
    localparam logic [7:0] CMD_OPER = 8'hCC;
    localparam logic [7:0] CMD_NOOP = 8'hDD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_GET_FUN,
        ST_ALU_RUN,
        ST_ALU_WAIT,
        ST_SEND_LO,
        ST_SEND_HI
    } seq_state_t;

endpackage

// File: rtl/alu_timeout_counter.sv
// Cycle counter bounding the wait for an ALU result; done pulses on the
// enabled cycle whose increment would reach TIMEOUT.
module alu_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign done = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Frame controller between the UART byte streams and the ALU: collects a
// command frame, starts the ALU, and returns the result low byte first.
module alu_cmd_sequencer
    import alu_sys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int unsigned FUN_WIDTH  = ALU_FUN_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER = DATA_WIDTH'(CMD_OPER),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOOP = DATA_WIDTH'(CMD_NOOP),
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   Rx_Data,
    input  logic                    Rx_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_Out,
    input  logic                    ALU_Out_Valid,
    input  logic                    Tx_Ready,
    output logic [DATA_WIDTH-1:0]   ALU_A,
    output logic [DATA_WIDTH-1:0]   ALU_B,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    ALU_EN,
    output logic                    ALU_Gate_En,
    output logic [DATA_WIDTH-1:0]   Tx_Data,
    output logic                    Tx_Valid,
    output logic                    Busy,
    output logic                    Err_Timeout,
    output logic                    Rx_Overrun
);

    seq_state_t              state;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    result_hit;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic                    cnt_done;

    // ALU_EN is registered out of ALU_RUN, so it is visible during the first
    // ALU_WAIT cycle; a result strobe in that cycle is not accepted.
    assign result_hit = (state == ST_ALU_WAIT) && ALU_Out_Valid && !ALU_EN;
    assign cnt_clear  = (state == ST_ALU_RUN);
    assign cnt_en     = (state == ST_ALU_WAIT) && !result_hit;
    assign Busy       = (state != ST_IDLE);

    alu_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (CLK),
        .rst   (RST),
        .clear (cnt_clear),
        .enable(cnt_en),
        .done  (cnt_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            ALU_A       <= '0;
            ALU_B       <= '0;
            ALU_FUN     <= '0;
            ALU_EN      <= 1'b0;
            ALU_Gate_En <= 1'b0;
            Tx_Data     <= '0;
            Tx_Valid    <= 1'b0;
            Err_Timeout <= 1'b0;
            Rx_Overrun  <= 1'b0;
            result      <= '0;
        end else begin
            ALU_EN      <= 1'b0;
            Err_Timeout <= 1'b0;
            Rx_Overrun  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Rx_Valid && (Rx_Data == CMD_ALU_OPER)) begin
                        state <= ST_GET_A;
                    end else if (Rx_Valid && (Rx_Data == CMD_ALU_NOOP)) begin
                        state <= ST_GET_FUN;
                    end
                end
                ST_GET_A: begin
                    if (Rx_Valid) begin
                        ALU_A <= Rx_Data;
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (Rx_Valid) begin
                        ALU_B <= Rx_Data;
                        state <= ST_GET_FUN;
                    end
                end
                ST_GET_FUN: begin
                    if (Rx_Valid) begin
                        ALU_FUN     <= Rx_Data[FUN_WIDTH-1:0];
                        ALU_Gate_En <= 1'b1;
                        state       <= ST_ALU_RUN;
                    end
                end
                ST_ALU_RUN: begin
                    ALU_EN     <= 1'b1;
                    Rx_Overrun <= Rx_Valid;
                    state      <= ST_ALU_WAIT;
                end
                ST_ALU_WAIT: begin
                    Rx_Overrun <= Rx_Valid;
                    if (result_hit) begin
                        result      <= ALU_Out;
                        Tx_Data     <= ALU_Out[DATA_WIDTH-1:0];
                        Tx_Valid    <= 1'b1;
                        ALU_Gate_En <= 1'b0;
                        state       <= ST_SEND_LO;
                    end else if (cnt_done) begin
                        Err_Timeout <= 1'b1;
                        ALU_Gate_En <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_SEND_LO: begin
                    Rx_Overrun <= Rx_Valid;
                    if (Tx_Valid && Tx_Ready) begin
                        Tx_Data <= result[2*DATA_WIDTH-1:DATA_WIDTH];
                        state   <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    Rx_Overrun <= Rx_Valid;
                    if (Tx_Valid && Tx_Ready) begin
                        Tx_Data  <= '0;
                        Tx_Valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
